// File: rtl/shift_arbiter_if.sv
// Handshake bundle between two shift requesters, the arbiter and the result consumer.
// The arbiter uses the slave view; the environment driving requests uses the master view.
interface shift_arbiter_if;
    logic        i_req0_valid;
    logic        o_req0_ready;
    logic [31:0] i_req0_a;
    logic [31:0] i_req0_b;
    logic [1:0]  i_req0_mode;

    logic        i_req1_valid;
    logic        o_req1_ready;
    logic [31:0] i_req1_a;
    logic [31:0] i_req1_b;
    logic [1:0]  i_req1_mode;

    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic        o_rsp_id;
    logic [31:0] o_rsp_data;

    modport slave (
        input  i_req0_valid, i_req0_a, i_req0_b, i_req0_mode,
        input  i_req1_valid, i_req1_a, i_req1_b, i_req1_mode,
        input  i_rsp_ready,
        output o_req0_ready, o_req1_ready,
        output o_rsp_valid, o_rsp_id, o_rsp_data
    );

    modport master (
        output i_req0_valid, i_req0_a, i_req0_b, i_req0_mode,
        output i_req1_valid, i_req1_a, i_req1_b, i_req1_mode,
        output i_rsp_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp_valid, o_rsp_id, o_rsp_data
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one combinational 32-bit barrel shifter between two requesters.
// Results are registered with the issuing requester ID and held until consumed.
// Shift modes: 0 = logical left, 1 = logical right, 2 = arithmetic right, 3 = rotate left.
module shift_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    shift_arbiter_if.slave   bus,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_issue_cnt
);

    localparam logic [1:0] ModeSll = 2'd0;
    localparam logic [1:0] ModeSrl = 2'd1;
    localparam logic [1:0] ModeSra = 2'd2;
    localparam logic [1:0] ModeRol = 2'd3;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    logic        free;
    logic        grant_valid;
    logic        grant_id;
    logic [31:0] sh_a;
    logic [31:0] sh_b;
    logic [1:0]  sh_mode;
    logic [4:0]  sh_amt;
    logic        sh_big;
    logic [63:0] sh_rot;
    logic [31:0] sh_res;

    // Round-robin grant; requests are ignored while reset is asserted.
    always_comb begin
        free        = !rsp_valid_q || bus.i_rsp_ready;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (free && i_rst_n) begin
            if (bus.i_req0_valid && bus.i_req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_q;
            end else if (bus.i_req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus.i_req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Operand mux from the granted requester and the shared barrel shifter.
    always_comb begin
        sh_a    = grant_id ? bus.i_req1_a    : bus.i_req0_a;
        sh_b    = grant_id ? bus.i_req1_b    : bus.i_req0_b;
        sh_mode = grant_id ? bus.i_req1_mode : bus.i_req0_mode;
        sh_amt  = sh_b[4:0];
        // Any amount of 32 or more saturates the non-rotating shifts.
        sh_big  = |sh_b[31:5];
        sh_rot  = {sh_a, sh_a} << sh_amt;
        sh_res  = '0;
        unique case (sh_mode)
            ModeSll: sh_res = sh_big ? 32'h0 : (sh_a << sh_amt);
            ModeSrl: sh_res = sh_big ? 32'h0 : (sh_a >> sh_amt);
            ModeSra: sh_res = sh_big ? {32{sh_a[31]}} : 32'($signed(sh_a) >>> sh_amt);
            ModeRol: sh_res = sh_rot[63:32];
            default: sh_res = '0;
        endcase
    end

    // Next state of the result slot, round-robin pointer and issue counter.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        last_d      = last_q;
        issue_cnt_d = issue_cnt_q;
        if (grant_valid) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_id;
            rsp_data_d  = sh_res;
            last_d      = grant_id;
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end else if (rsp_valid_q && bus.i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; last resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 32'h0;
            last_q      <= 1'b1;
            issue_cnt_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            last_q      <= last_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    // Output drive.
    always_comb begin
        bus.o_req0_ready = grant_valid && !grant_id;
        bus.o_req1_ready = grant_valid && grant_id;
        bus.o_rsp_valid  = rsp_valid_q;
        bus.o_rsp_id     = rsp_id_q;
        bus.o_rsp_data   = rsp_data_q;
        o_busy           = rsp_valid_q;
        o_issue_cnt      = issue_cnt_q;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one instance of the combinational 32-bit barrel `shifter` between two requesters, such as the integer ALU path and a multi-cycle unit. Each request uses a valid/ready handshake, and the block grants one requester per cycle using round-robin arbitration. Each result is registered together with the ID of the requester that issued it, and is held until the consumer accepts it. A wrapping counter of accepted operations is exported for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of the issued-operation counter

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst_n  in  1  asynchronous reset, active-low
- i_req0_valid  in  1  requester 0 has an operation pending
- o_req0_ready  out  1  requester 0 is accepted this cycle
- i_req0_a  in  32  requester 0 operand to shift
- i_req0_b  in  32  requester 0 shift amount (full 32 bits, passed to the shifter)
- i_req0_mode  in  2  requester 0 shift mode (passed unchanged to the shifter)
- i_req1_valid / o_req1_ready / i_req1_a / i_req1_b / i_req1_mode: same meanings and widths for requester 1
- o_rsp_valid  out  1  the result register holds an unconsumed result
- i_rsp_ready  in  1  the consumer accepts the result this cycle
- o_rsp_id  out  1  requester that issued the held result (0 or 1)
- o_rsp_data  out  32  held shifted result
- o_busy  out  1  equals o_rsp_valid; the slot is occupied
- o_issue_cnt  out  CNT_W  number of accepted requests, wrapping

## Operation
- Slot free: `free = !o_rsp_valid || i_rsp_ready`.
- Round-robin pointer `last` (1 bit) records the requester granted most recently.
- Grant rules, evaluated only when `free` is 1:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than `last` is granted.
  - Neither valid: no grant.
- When `free` is 0, there is no grant.
- `o_reqN_ready = free & grantN`. This is combinational from the valids, `last`, `o_rsp_valid` and `i_rsp_ready`, and does not depend on operand values.
- The shifter inputs (a, b, mode) are multiplexed combinationally from the granted requester.
- Mode encoding and the handling of b ≥ 32 are defined by the shifter; this block does not alter either. In particular:
  - Logical left and logical right shifts produce 0.
  - Arithmetic right shift produces 32 copies of a[31].
- On an accepted request at a clock edge:
  - the shifter output is loaded into `o_rsp_data`;
  - `o_rsp_id` is loaded with the granted ID;
  - `o_rsp_valid` is set to 1;
  - `last` is set to the granted ID;
  - `o_issue_cnt` is incremented.
- On a consume (`o_rsp_valid & i_rsp_ready`) with no new grant in the same cycle, `o_rsp_valid` is cleared.
- Simultaneous consume and grant: the new result replaces the old one back-to-back, and `o_rsp_valid` stays 1.
- While `o_rsp_valid` is 1, `o_rsp_data` and `o_rsp_id` hold steady until consumed.
- `last` and `o_issue_cnt` change only when a grant occurs.
- `o_issue_cnt` wraps from 2^CNT_W−1 to 0 with no flag.
- A requester must hold valid and its operands stable until it sees ready. The block does not check for this.

## Timing
- Reset values, applied asynchronously while i_rst_n=0:
  - o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0, o_issue_cnt=0;
  - last=1, so requester 0 wins the first contention.
- Reset mid-operation discards any held result. The ready outputs go to 0 only because valids are ignored during reset.
- Latency: a request accepted at edge N is visible on o_rsp_* immediately after edge N.
- Throughput is one operation per cycle when i_rsp_ready is held at 1.
- Under continuous contention with i_rsp_ready held at 1, grants alternate 0,1,0,1,…
- With i_rsp_ready=0 and o_rsp_valid=1, both ready outputs are 0. The requesters stall, and no operand is sampled.
- Release from reset takes effect at the first rising edge after i_rst_n rises.

## Test plan
- Single op: req0 with a=0x0000_0001, b=4, left-shift mode, rsp_ready=1 → o_req0_ready=1 in the same cycle; next cycle o_rsp_valid=1, o_rsp_id=0, o_rsp_data=0x0000_0010, o_issue_cnt=1.
- Contention after reset: both valid for 4 cycles with rsp_ready=1 → grant sequence 0,1,0,1; o_rsp_id follows the same sequence one cycle later; o_issue_cnt=4.
- Backpressure: result held with rsp_ready=0 for 3 cycles while both requesters are valid → both ready outputs are 0 throughout; o_rsp_data is unchanged. Raising rsp_ready produces a consume and a new grant in the same cycle, and o_rsp_valid stays 1.
- Large shift amount: req1 with a=0x8000_0000, b=0x0000_0100, arithmetic-right mode → o_rsp_data=0xFFFF_FFFF and o_rsp_id=1. The same operands in logical-right mode → 0x0000_0000.
- Reset mid-operation: assert i_rst_n=0 between edges while o_rsp_valid=1 and o_issue_cnt=5 → o_rsp_valid=0 and o_issue_cnt=0 immediately, without waiting for a clock edge. After release, the first contention grants requester 0.
- Counter wrap with CNT_W=4: 17 accepted ops → o_issue_cnt=1.
